// File: rtl/fwd_hazard_unit.sv
// Operand forwarding from p3/p4/p5 into p2 plus a load-use interlock FSM.
// Define FWD_HAZARD_STATS_EN to build the saturating forward/stall statistics counters.
module fwd_hazard_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     p2_valid,
    input  logic [NSRC*ADDR_W-1:0]   p2_rd_addr,
    input  logic [NSRC-1:0]          p2_src_used,
    input  logic [ADDR_W-1:0]        p3_wr_addr,
    input  logic [ADDR_W-1:0]        p4_wr_addr,
    input  logic [ADDR_W-1:0]        p5_wr_addr,
    input  logic                     p3_wr_en,
    input  logic                     p4_wr_en,
    input  logic                     p5_wr_en,
    input  logic [DATA_W-1:0]        p3_data,
    input  logic [DATA_W-1:0]        p4_data,
    input  logic [DATA_W-1:0]        p5_data,
    input  logic                     p3_is_load,
    input  logic                     flush,
    output logic [NSRC*DATA_W-1:0]   fwd_data,
    output logic [NSRC-1:0]          fwd_sel,
    output logic                     stall,
    output logic                     bubble_p3,
    output logic [15:0]              stat_fwd_cnt,
    output logic [15:0]              stat_stall_cnt,
    input  logic                     stat_clr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [1:0]              cnt_r;
    logic [1:0]              cnt_nxt_s;
    logic [NSRC-1:0]         m3_s;
    logic [NSRC-1:0]         m4_s;
    logic [NSRC-1:0]         m5_s;
    logic [NSRC*DATA_W-1:0]  fwd_data_s;
    logic [NSRC-1:0]         fwd_sel_s;
    logic                    load_use_s;
    logic                    stall_s;

    // Per-source address match against each enabled in-flight destination
    always_comb begin
        m3_s = '0;
        m4_s = '0;
        m5_s = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (p2_valid && p2_src_used[i]) begin
                m3_s[i] = p3_wr_en && (p2_rd_addr[i*ADDR_W +: ADDR_W] == p3_wr_addr);
                m4_s[i] = p4_wr_en && (p2_rd_addr[i*ADDR_W +: ADDR_W] == p4_wr_addr);
                m5_s[i] = p5_wr_en && (p2_rd_addr[i*ADDR_W +: ADDR_W] == p5_wr_addr);
            end else begin
                m3_s[i] = 1'b0;
                m4_s[i] = 1'b0;
                m5_s[i] = 1'b0;
            end
        end
    end

    // Youngest enabled producer wins; a load still in p3 shadows the older stages
    always_comb begin
        fwd_data_s = '0;
        fwd_sel_s  = '0;
        load_use_s = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (m3_s[i]) begin
                if (p3_is_load) begin
                    load_use_s = 1'b1;
                end else begin
                    fwd_sel_s[i]                      = 1'b1;
                    fwd_data_s[i*DATA_W +: DATA_W]    = p3_data;
                end
            end else if (m4_s[i]) begin
                fwd_sel_s[i]                          = 1'b1;
                fwd_data_s[i*DATA_W +: DATA_W]        = p4_data;
            end else if (m5_s[i]) begin
                fwd_sel_s[i]                          = 1'b1;
                fwd_data_s[i*DATA_W +: DATA_W]        = p5_data;
            end else begin
                fwd_sel_s[i]                          = 1'b0;
            end
        end
    end

    // Interlock state and remaining-stall counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Detection cycle stalls combinationally; STALL covers the remaining LOAD_LAT-1 cycles
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 2'd0;
                end else if (load_use_s) begin
                    stall_s = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nxt_s = ST_STALL;
                        cnt_nxt_s   = CNT_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 2'd0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    stall_s = 1'b1;
                    if (cnt_r == 2'd1) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 2'd0;
                    end else begin
                        cnt_nxt_s   = cnt_r - 2'd1;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // Reset forces every output low immediately, including the combinational paths
    assign fwd_data  = reset ? '0 : fwd_data_s;
    assign fwd_sel   = reset ? '0 : fwd_sel_s;
    assign stall     = reset ? 1'b0 : stall_s;
    assign bubble_p3 = stall;

`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stat_fwd_r;
    logic [15:0] stat_stall_r;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[16]) begin
            sat_add16 = 16'hFFFF;
        end else begin
            sat_add16 = sum[15:0];
        end
    endfunction

    function automatic logic [15:0] popcount(input logic [NSRC-1:0] v);
        logic [15:0] c;
        c = 16'd0;
        for (int i = 0; i < NSRC; i++) begin
            c = c + {15'd0, v[i]};
        end
        return c;
    endfunction

    // Saturating statistics; clear dominates increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_fwd_r   <= 16'd0;
            stat_stall_r <= 16'd0;
        end else if (stat_clr) begin
            stat_fwd_r   <= 16'd0;
            stat_stall_r <= 16'd0;
        end else if (stall_s) begin
            stat_stall_r <= sat_add16(stat_stall_r, 16'd1);
        end else begin
            stat_fwd_r   <= sat_add16(stat_fwd_r, popcount(fwd_sel_s));
        end
    end

    assign stat_fwd_cnt   = stat_fwd_r;
    assign stat_stall_cnt = stat_stall_r;
`else
    logic unused_stat_clr_s;
    assign unused_stat_clr_s = stat_clr;
    assign stat_fwd_cnt      = 16'd0;
    assign stat_stall_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (LOAD_LAT 1,2,3) driven in parallel,
// checked against a stage-list forwarding model and a remaining-stall-cycles model.
module tb_fwd_hazard_unit;

    logic        clock;
    logic        reset;
    logic        p2_valid;
    logic [5:0]  p2_rd_addr;
    logic [1:0]  p2_src_used;
    logic [2:0]  p3_wr_addr, p4_wr_addr, p5_wr_addr;
    logic        p3_wr_en, p4_wr_en, p5_wr_en;
    logic [15:0] p3_data, p4_data, p5_data;
    logic        p3_is_load;
    logic        flush;
    logic        stat_clr;

    logic [31:0] fwd_data_a [3];
    logic [1:0]  fwd_sel_a  [3];
    logic        stall_a    [3];
    logic        bubble_a   [3];
    logic [15:0] sfc_a      [3];
    logic [15:0] ssc_a      [3];

    int checks = 0;
    int errors = 0;

    int lat_tab [3] = '{1, 2, 3};
    int rem     [3];
    int m_fwd   [3];
    int m_stl   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fwd_hazard_unit #(.DATA_W(16), .ADDR_W(3), .NSRC(2), .LOAD_LAT(g + 1)) u_dut (
            .clock(clock), .reset(reset), .p2_valid(p2_valid), .p2_rd_addr(p2_rd_addr),
            .p2_src_used(p2_src_used), .p3_wr_addr(p3_wr_addr), .p4_wr_addr(p4_wr_addr),
            .p5_wr_addr(p5_wr_addr), .p3_wr_en(p3_wr_en), .p4_wr_en(p4_wr_en),
            .p5_wr_en(p5_wr_en), .p3_data(p3_data), .p4_data(p4_data), .p5_data(p5_data),
            .p3_is_load(p3_is_load), .flush(flush), .fwd_data(fwd_data_a[g]),
            .fwd_sel(fwd_sel_a[g]), .stall(stall_a[g]), .bubble_p3(bubble_a[g]),
            .stat_fwd_cnt(sfc_a[g]), .stat_stall_cnt(ssc_a[g]), .stat_clr(stat_clr)
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: walk the in-flight stages youngest first, first enabled address hit decides.
    // Result packing: {load_use, sel[1:0], data[31:0]}
    function automatic logic [34:0] model_eval();
        logic [2:0]  st_addr [3];
        logic        st_en   [3];
        logic [15:0] st_data [3];
        logic [31:0] d;
        logic [1:0]  s;
        logic        lu;
        logic [2:0]  a;
        st_addr = '{p3_wr_addr, p4_wr_addr, p5_wr_addr};
        st_en   = '{p3_wr_en, p4_wr_en, p5_wr_en};
        st_data = '{p3_data, p4_data, p5_data};
        d  = 32'd0;
        s  = 2'd0;
        lu = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (p2_valid && p2_src_used[i]) begin
                a = p2_rd_addr[i*3 +: 3];
                for (int k = 0; k < 3; k++) begin
                    if (st_en[k] && st_addr[k] == a) begin
                        if (k == 0 && p3_is_load) begin
                            lu = 1'b1;
                        end else begin
                            s[i] = 1'b1;
                            d[i*16 +: 16] = st_data[k];
                        end
                        break;
                    end
                end
            end
        end
        return {lu, s, d};
    endfunction

    function automatic logic model_lu();
        logic [34:0] t;
        t = model_eval();
        return t[34];
    endfunction

    function automatic logic [1:0] model_sel();
        logic [34:0] t;
        t = model_eval();
        return reset ? 2'd0 : t[33:32];
    endfunction

    function automatic logic [31:0] model_data();
        logic [34:0] t;
        t = model_eval();
        return reset ? 32'd0 : t[31:0];
    endfunction

    function automatic logic exp_stall(int j);
        if (reset || flush) return 1'b0;
        if (rem[j] > 0) return 1'b1;
        return model_lu();
    endfunction

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Model state: remaining stall cycles and statistics per instance
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 3; j++) begin
                rem[j]   <= 0;
                m_fwd[j] <= 0;
                m_stl[j] <= 0;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (flush)               rem[j] <= 0;
                else if (rem[j] > 0)     rem[j] <= rem[j] - 1;
                else if (model_lu())     rem[j] <= lat_tab[j] - 1;
                if (stat_clr) begin
                    m_fwd[j] <= 0;
                    m_stl[j] <= 0;
                end else if (exp_stall(j)) begin
                    m_stl[j] <= sat16(m_stl[j] + 1);
                end else begin
                    m_fwd[j] <= sat16(m_fwd[j] + $countones(model_sel()));
                end
            end
        end
    end

    task automatic idle_inputs();
        p2_valid = 1'b0; p2_rd_addr = 6'd0; p2_src_used = 2'd0;
        p3_wr_addr = 3'd0; p4_wr_addr = 3'd0; p5_wr_addr = 3'd0;
        p3_wr_en = 1'b0; p4_wr_en = 1'b0; p5_wr_en = 1'b0;
        p3_data = 16'd0; p4_data = 16'd0; p5_data = 16'd0;
        p3_is_load = 1'b0; flush = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        p2_valid = 1'b1; p2_src_used = 2'b11; p2_rd_addr = {3'd4, 3'd3};
        p3_wr_en = 1'b1; p3_wr_addr = 3'd3; p3_is_load = 1'b1;
        p4_wr_en = 1'b1; p4_wr_addr = 3'd4; p4_data = 16'hBEEF;
        #2;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (fwd_data_a[j] !== 32'd0 || fwd_sel_a[j] !== 2'd0 || stall_a[j] !== 1'b0 ||
                bubble_a[j] !== 1'b0 || sfc_a[j] !== 16'd0 || ssc_a[j] !== 16'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: data=%h sel=%b stall=%b bub=%b sfc=%h ssc=%h, required all zero",
                         j, fwd_data_a[j], fwd_sel_a[j], stall_a[j], bubble_a[j], sfc_a[j], ssc_a[j]);
            end
        end
        tick();
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_forwarding();
        idle_inputs();
        p2_valid = 1'b1; p2_src_used = 2'b01; p2_rd_addr = {3'd0, 3'd2};
        p3_wr_en = 1'b1; p3_wr_addr = 3'd2; p3_data = 16'h1234;
        p4_wr_en = 1'b1; p4_wr_addr = 3'd2; p4_data = 16'hAAAA;
        #1;
        checks++;
        if (fwd_sel_a[0][0] !== 1'b1 || fwd_data_a[0][15:0] !== 16'h1234) begin
            errors++;
            $display("FAIL fwd_p3_priority: sel=%b data=%h, required 1 1234", fwd_sel_a[0][0], fwd_data_a[0][15:0]);
        end
        tick();
        idle_inputs();
        p2_valid = 1'b1; p2_src_used = 2'b10; p2_rd_addr = {3'd5, 3'd0};
        p3_wr_en = 1'b0; p3_wr_addr = 3'd5; p3_data = 16'h7777;
        p5_wr_en = 1'b1; p5_wr_addr = 3'd5; p5_data = 16'h00FF;
        #1;
        checks++;
        if (fwd_sel_a[0] !== 2'b10 || fwd_data_a[0] !== 32'h00FF_0000) begin
            errors++;
            $display("FAIL fwd_skip_disabled: sel=%b data=%h, required 10 00ff0000", fwd_sel_a[0], fwd_data_a[0]);
        end
        tick();
        p2_src_used = 2'b00;
        #1;
        checks++;
        if (fwd_sel_a[0] !== 2'b00 || fwd_data_a[0] !== 32'd0) begin
            errors++;
            $display("FAIL fwd_src_unused: sel=%b data=%h, required 00 0", fwd_sel_a[0], fwd_data_a[0]);
        end
        tick();
        idle_inputs();
        p2_valid = 1'b1; p2_src_used = 2'b11; p2_rd_addr = {3'd0, 3'd0};
        p5_wr_en = 1'b1; p5_wr_addr = 3'd0; p5_data = 16'h5555;
        #1;
        checks++;
        if (fwd_sel_a[0] !== 2'b11 || fwd_data_a[0] !== 32'h5555_5555) begin
            errors++;
            $display("FAIL fwd_reg0: sel=%b data=%h, required 11 55555555", fwd_sel_a[0], fwd_data_a[0]);
        end
        tick();
        idle_inputs();
    endtask

    // Load in p3 feeding src0, then walks through p4/p5 while the stall runs
    task automatic test_load_use();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            p2_valid = 1'b1; p2_src_used = 2'b01; p2_rd_addr = {3'd0, 3'd3};
            if (c == 0) begin
                p3_wr_en = 1'b1; p3_wr_addr = 3'd3; p3_is_load = 1'b1;
                p4_wr_en = 1'b1; p4_wr_addr = 3'd3; p4_data = 16'h9999;
            end else if (c == 1) begin
                p4_wr_en = 1'b1; p4_wr_addr = 3'd3; p4_data = 16'h0042;
            end else if (c == 2) begin
                p5_wr_en = 1'b1; p5_wr_addr = 3'd3; p5_data = 16'h0042;
            end
            #1;
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (stall_a[j] !== (c < lat_tab[j]) || bubble_a[j] !== (c < lat_tab[j])) begin
                    errors++;
                    $display("FAIL load_use_len dut%0d cyc%0d: stall=%b bubble=%b, required %b",
                             j, c, stall_a[j], bubble_a[j], (c < lat_tab[j]));
                end
            end
            checks++;
            if (c == 0 && fwd_sel_a[0] !== 2'b00) begin
                errors++;
                $display("FAIL load_no_fallthrough: sel=%b, required 00", fwd_sel_a[0]);
            end else if (c == 1 && (fwd_sel_a[0] !== 2'b01 || fwd_data_a[0] !== 32'h0000_0042)) begin
                errors++;
                $display("FAIL load_fwd_p4: sel=%b data=%h, required 01 00000042", fwd_sel_a[0], fwd_data_a[0]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        p2_valid = 1'b1; p2_src_used = 2'b01; p2_rd_addr = {3'd0, 3'd1};
        p3_wr_en = 1'b1; p3_wr_addr = 3'd1; p3_is_load = 1'b1;
        #1;
        checks++;
        if (stall_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre dut1: stall=%b, required 1", stall_a[1]);
        end
        tick();
        idle_inputs();
        flush = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (stall_a[j] !== 1'b0) begin
                errors++;
                $display("FAIL flush_kills_stall dut%0d: stall=%b, required 0", j, stall_a[j]);
            end
        end
        tick();
        flush = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (stall_a[j] !== 1'b0) begin
                errors++;
                $display("FAIL flush_idle_after dut%0d: stall=%b, required 0", j, stall_a[j]);
            end
        end
        tick();
        p2_valid = 1'b1; p2_src_used = 2'b10; p2_rd_addr = {3'd6, 3'd0};
        p3_wr_en = 1'b1; p3_wr_addr = 3'd6; p3_is_load = 1'b1; flush = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (stall_a[j] !== 1'b0) begin
                errors++;
                $display("FAIL flush_same_cycle dut%0d: stall=%b, required 0", j, stall_a[j]);
            end
        end
        tick();
        idle_inputs();
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (stall_a[j] !== 1'b0) begin
                errors++;
                $display("FAIL flush_same_after dut%0d: stall=%b, required 0", j, stall_a[j]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        p2_valid = 1'b1; p2_src_used = 2'b11; p2_rd_addr = {3'd4, 3'd2};
        p3_wr_en = 1'b1; p3_wr_addr = 3'd2; p3_is_load = 1'b1;
        p4_wr_en = 1'b1; p4_wr_addr = 3'd4; p4_data = 16'hCAFE;
        tick();
        #2;
        reset = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (stall_a[j] !== 1'b0 || fwd_sel_a[j] !== 2'd0 || fwd_data_a[j] !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_stall dut%0d: stall=%b sel=%b data=%h, required 0 0 0",
                         j, stall_a[j], fwd_sel_a[j], fwd_data_a[j]);
            end
        end
        tick();
        idle_inputs();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (stall_a[j] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_no_residual dut%0d cyc%0d: stall=%b, required 0", j, c, stall_a[j]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random(int n);
        logic [1:0]  es;
        logic [31:0] ed;
        logic        est;
        for (int c = 0; c < n; c++) begin
            p2_valid    = ($urandom_range(0, 9) != 0);
            p2_src_used = 2'($urandom_range(0, 3));
            p2_rd_addr  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
            p3_wr_addr  = 3'($urandom_range(0, 3));
            p4_wr_addr  = 3'($urandom_range(0, 3));
            p5_wr_addr  = 3'($urandom_range(0, 3));
            p3_wr_en    = ($urandom_range(0, 2) != 0);
            p4_wr_en    = ($urandom_range(0, 2) != 0);
            p5_wr_en    = ($urandom_range(0, 2) != 0);
            p3_data     = 16'($urandom);
            p4_data     = 16'($urandom);
            p5_data     = 16'($urandom);
            p3_is_load  = ($urandom_range(0, 2) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            stat_clr    = ($urandom_range(0, 29) == 0);
            #1;
            es = model_sel();
            ed = model_data();
            for (int j = 0; j < 3; j++) begin
                est = exp_stall(j);
                checks++;
                if (fwd_sel_a[j] !== es || fwd_data_a[j] !== ed) begin
                    errors++;
                    $display("FAIL rand_fwd dut%0d cyc%0d: sel=%b data=%h, required %b %h", j, c, fwd_sel_a[j], fwd_data_a[j], es, ed);
                end
                checks++;
                if (stall_a[j] !== est || bubble_a[j] !== est) begin
                    errors++;
                    $display("FAIL rand_stall dut%0d cyc%0d: stall=%b bubble=%b, required %b", j, c, stall_a[j], bubble_a[j], est);
                end
`ifdef FWD_HAZARD_STATS_EN
                checks++;
                if (sfc_a[j] !== 16'(m_fwd[j]) || ssc_a[j] !== 16'(m_stl[j])) begin
                    errors++;
                    $display("FAIL rand_stats dut%0d cyc%0d: fwd=%0d stall=%0d, required %0d %0d", j, c, sfc_a[j], ssc_a[j], m_fwd[j], m_stl[j]);
                end
`else
                checks++;
                if (sfc_a[j] !== 16'd0 || ssc_a[j] !== 16'd0) begin
                    errors++;
                    $display("FAIL stats_absent dut%0d: fwd=%h stall=%h, required 0 0", j, sfc_a[j], ssc_a[j]);
                end
`endif
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick();
    endtask

`ifdef FWD_HAZARD_STATS_EN
    task automatic set_double_fwd();
        idle_inputs();
        p2_valid = 1'b1; p2_src_used = 2'b11; p2_rd_addr = {3'd2, 3'd1};
        p4_wr_en = 1'b1; p4_wr_addr = 3'd1; p4_data = 16'h1111;
        p5_wr_en = 1'b1; p5_wr_addr = 3'd2; p5_data = 16'h2222;
    endtask

    task automatic test_stats();
        idle_inputs();
        stat_clr = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            set_double_fwd();
            tick();
        end
        idle_inputs();
        p2_valid = 1'b1; p2_src_used = 2'b01; p2_rd_addr = {3'd0, 3'd3};
        p3_wr_en = 1'b1; p3_wr_addr = 3'd3; p3_is_load = 1'b1;
        tick();
        idle_inputs();
        tick();
        #1;
        checks++;
        if (sfc_a[1] !== 16'd6 || ssc_a[1] !== 16'd2) begin
            errors++;
            $display("FAIL stats_count dut1: fwd=%0d stall=%0d, required 6 2", sfc_a[1], ssc_a[1]);
        end
        tick();
        set_double_fwd();
        stat_clr = 1'b1;
        tick();
        idle_inputs();
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (sfc_a[j] !== 16'd0 || ssc_a[j] !== 16'd0) begin
                errors++;
                $display("FAIL stats_clear dut%0d: fwd=%0d stall=%0d, required 0 0", j, sfc_a[j], ssc_a[j]);
            end
        end
        set_double_fwd();
        for (int c = 0; c < 32770; c++) tick();
        #1;
        checks++;
        if (sfc_a[0] !== 16'hFFFF || sfc_a[0] !== 16'(m_fwd[0])) begin
            errors++;
            $display("FAIL stats_saturate: fwd=%h, required ffff", sfc_a[0]);
        end
        tick();
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_flush();
        test_reset_mid_stall();
        test_random(600);
`ifdef FWD_HAZARD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
